// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew: realigns skewed array columns into rows and buffers them for write-back.
module systolic_output_deskew #(
  parameter int ACC_WIDTH   = 32,
  parameter int N_SIZE      = 32,
  parameter int num_of_raws = 512,
  parameter int ADDR_WIDTH  = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_SIZE-1:0]            col_valid,
  input  logic [N_SIZE*ACC_WIDTH-1:0]  col_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_SIZE*ACC_WIDTH-1:0]  out_data,
  output logic [ADDR_WIDTH-1:0]        out_row_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic                         skew_err
);
  localparam int DW = N_SIZE*ACC_WIDTH;
  localparam int EW = ADDR_WIDTH+DW;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
  state_t state_q;
  logic [N_SIZE-1:0] dv;
  logic [DW-1:0] dd;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] rows_q;
  logic ovf_q, skw_q, aligned, partial, full, pop, push, wr, last;
  genvar j;
  for (j = 0; j < N_SIZE; j++) begin : g_col
    localparam int D = N_SIZE-1-j;
    if (D == 0) begin : g_pass
      assign dv[j] = col_valid[j];
      assign dd[j*ACC_WIDTH +: ACC_WIDTH] = col_data[j*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      logic [D-1:0] v_q;
      logic [D-1:0][ACC_WIDTH-1:0] d_q;
      always_ff @(posedge clk) begin
        for (int k = D-1; k > 0; k--) begin
          v_q[k] <= v_q[k-1];
          d_q[k] <= d_q[k-1];
        end
        v_q[0] <= col_valid[j];
        d_q[0] <= col_data[j*ACC_WIDTH +: ACC_WIDTH];
        if (rst) v_q <= '0;
      end
      assign dv[j] = v_q[D-1];
      assign dd[j*ACC_WIDTH +: ACC_WIDTH] = d_q[D-1];
    end
  end
  always_comb begin
    aligned = &dv;
    partial = |dv && !aligned;
    full = cnt_q == CW'(FIFO_DEPTH);
    out_valid = cnt_q != '0;
    pop = out_valid && out_ready;
    push = aligned && state_q == COLLECT;
    wr = push && (!full || pop);
    last = rows_q == ADDR_WIDTH'(num_of_raws-1);
    done = state_q == DRAIN && pop && cnt_q == CW'(1);
    {out_row_idx, out_data} = out_valid ? mem_q[rp_q] : '0;
    busy = state_q != IDLE;
    overflow = ovf_q;
    skew_err = skw_q;
  end
  // dropped rows still advance rows_q so the tile always reaches DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      rows_q <= '0;
      ovf_q <= 1'b0;
      skw_q <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wp_q] <= {rows_q, dd};
        wp_q <= wp_q + PW'(1);
      end
      if (pop) rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_q + CW'(wr) - CW'(pop);
      if (push) rows_q <= rows_q + ADDR_WIDTH'(1);
      if (push && full && !pop) ovf_q <= 1'b1;
      if (partial && state_q != IDLE) skw_q <= 1'b1;
      if (state_q == IDLE && start) begin
        state_q <= COLLECT;
        rows_q <= '0;
        ovf_q <= 1'b0;
        skw_q <= 1'b0;
      end else if (state_q == COLLECT && push && last) state_q <= DRAIN;
      else if (done) state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_systolic_output_deskew.sv
// tb_systolic_output_deskew: directed and randomized tiles checked against a queue-based model.
module tb_systolic_output_deskew;
  localparam int N = 4, R = 3, FD = 2, AW = 32, XW = 10, MAXC = 1024;
  localparam int DW = N*AW;
  logic clk = 0, rst = 1, start = 0, out_ready = 0;
  logic [N-1:0] col_valid = '0;
  logic [DW-1:0] col_data = '0;
  logic out_valid, busy, done, overflow, skew_err;
  logic [DW-1:0] out_data;
  logic [XW-1:0] out_row_idx;
  systolic_output_deskew #(.ACC_WIDTH(AW), .N_SIZE(N), .num_of_raws(R), .ADDR_WIDTH(XW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .col_valid(col_valid), .col_data(col_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row_idx(out_row_idx),
    .busy(busy), .done(done), .overflow(overflow), .skew_err(skew_err)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [XW-1:0] idx; logic [DW-1:0] d;} ent_t;
  ent_t q[$];
  int mode = 0, rows_in = 0, t = 0, vfrom = 0, n_cmp = 0, n_bad = 0;
  bit m_ovf = 0, m_skw = 0;
  logic hv [MAXC][N];
  logic [AW-1:0] hd [MAXC][N];
  task automatic chk(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, t, o, e);
    end
  endtask
  // column j's value driven at cycle c is seen at the alignment point at cycle c+N-1-j
  task automatic cyc(input bit st, input logic [N-1:0] v, input logic [DW-1:0] d, input bit rdy, input bit r);
    logic [N-1:0] av;
    logic [DW-1:0] ad, hdat;
    logic [XW-1:0] hidx;
    bit all, any, ev, pop, push, dn;
    start = st; col_valid = v; col_data = d; out_ready = rdy; rst = r;
    for (int j = 0; j < N; j++) begin
      hv[t][j] = v[j];
      hd[t][j] = d[j*AW +: AW];
    end
    av = '0; ad = '0;
    for (int j = 0; j < N; j++) begin
      int h;
      h = t-(N-1-j);
      if (h >= vfrom) begin
        av[j] = hv[h][j];
        ad[j*AW +: AW] = hd[h][j];
      end
    end
    all = &av; any = |av;
    ev = q.size() != 0;
    hdat = '0; hidx = '0;
    if (ev) begin
      hdat = q[0].d;
      hidx = q[0].idx;
    end
    pop = ev && rdy;
    dn = mode == 2 && pop && q.size() == 1;
    push = all && mode == 1;
    @(negedge clk);
    chk("out_valid", DW'(out_valid), DW'(ev));
    chk("out_data", out_data, hdat);
    chk("out_row_idx", DW'(out_row_idx), DW'(hidx));
    chk("busy", DW'(busy), DW'(mode != 0));
    chk("done", DW'(done), DW'(dn));
    chk("overflow", DW'(overflow), DW'(m_ovf));
    chk("skew_err", DW'(skew_err), DW'(m_skw));
    @(posedge clk);
    if (r) begin
      mode = 0; q.delete(); rows_in = 0; m_ovf = 0; m_skw = 0; vfrom = t+1;
    end else begin
      if (any && !all && mode != 0) m_skw = 1;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < FD) q.push_back('{idx: XW'(rows_in), d: ad});
        else m_ovf = 1;
        if (rows_in == R-1) mode = 2;
        rows_in++;
      end
      if (dn) mode = 0;
      else if (mode == 0 && st) begin
        mode = 1; rows_in = 0; m_ovf = 0; m_skw = 0;
      end
    end
    t++;
    #1;
  endtask
  // rows enter skewed: row r, column j is driven at cycle row0+r+j
  task automatic run(input int ncyc, input int row0, input int st_at, input int st2_at, input bit rmode,
                     input int ron, input int sr, input int sc, input bit rnd);
    for (int k = 0; k < ncyc; k++) begin
      logic [N-1:0] v;
      logic [DW-1:0] d;
      bit rdy;
      v = '0; d = '0;
      for (int j = 0; j < N; j++) begin
        int rr;
        rr = k-row0-j;
        if (rr >= 0 && rr < R && !(rr == sr && j == sc)) begin
          v[j] = 1'b1;
          d[j*AW +: AW] = rnd ? AW'($urandom) : AW'(10*rr+j);
        end
      end
      rdy = rmode ? (k >= ron || $urandom_range(0, 1) == 1) : (k >= ron);
      cyc(k == st_at || k == st2_at, v, d, rdy, 1'b0);
    end
  endtask
  initial begin
    @(posedge clk);
    #1;
    cyc(0, '0, '0, 1, 0);
    cyc(0, '0, '0, 1, 0);
    run(12, 1, 0, -1, 0, 0, -1, -1, 0);
    run(16, 1, 0, -1, 0, 11, -1, -1, 0);
    chk("bp_overflow_sticky", DW'(overflow), DW'(1));
    run(14, 1, 0, -1, 0, 6, -1, -1, 0);
    chk("full_pop_no_overflow", DW'(overflow), DW'(0));
    run(14, 1, 0, -1, 0, 0, 1, 2, 0);
    chk("skew_err_set", DW'(skew_err), DW'(1));
    chk("skew_tile_stuck", DW'(busy), DW'(1));
    cyc(0, '0, '0, 1, 1);
    run(8, 1, -1, -1, 0, 0, -1, -1, 0);
    run(14, 3, 0, 2, 0, 0, -1, -1, 0);
    run(5, 1, 0, -1, 0, 100, -1, -1, 0);
    cyc(0, '0, '0, 0, 1);
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", DW'(busy), DW'(0));
    run(12, 1, 0, -1, 0, 0, -1, -1, 0);
    for (int i = 0; i < 5; i++) run(40, $urandom_range(0, 4), 0, -1, 1, 20, -1, -1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
